// File: rtl/range_tracker_multi_if.sv
// Sample/command/readout bundle for range_tracker_multi.
// master: the sampler/controller side driving commands and rd_chan.
// slave:  the tracker itself.
interface range_tracker_multi_if #(
  parameter int WIDTH     = 10,
  parameter int CHANNELS  = 4,
  parameter int CNT_WIDTH = 8
);
  localparam int CH_W = $clog2(CHANNELS);

  logic [WIDTH-1:0]     data_in;
  logic [CH_W-1:0]      chan;
  logic                 sample;
  logic                 go;
  logic                 finish;
  logic                 clear_err;
  logic [CH_W-1:0]      rd_chan;
  logic [WIDTH-1:0]     min_out;
  logic [WIDTH-1:0]     max_out;
  logic [WIDTH-1:0]     range_out;
  logic [CNT_WIDTH-1:0] count_out;
  logic [CHANNELS-1:0]  busy;
  logic [CHANNELS-1:0]  done;
  logic [CHANNELS-1:0]  error;

  modport master (
    output data_in, chan, sample, go, finish, clear_err, rd_chan,
    input  min_out, max_out, range_out, count_out, busy, done, error
  );

  modport slave (
    input  data_in, chan, sample, go, finish, clear_err, rd_chan,
    output min_out, max_out, range_out, count_out, busy, done, error
  );
endinterface

// File: rtl/range_tracker_multi.sv
// Multi-channel min/max/range/count tracker sharing one sample bus.
// Each channel runs its own IDLE/ACTIVE/DONE/ERROR FSM; results are latched
// on finish and read back through a combinational rd_chan mux.
// Optional macro RANGE_TRACK_COUNT_EN: when defined, per-channel sample
// counters are built; otherwise count_out is tied to zero.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | no measurement since reset / error clear
// S_ACTIVE | measurement running, live min/max/count updating
// S_DONE   | measurement finished, latched results valid
// S_ERROR  | protocol violation, sticky until clear_err
module range_tracker_multi #(
  parameter int WIDTH     = 10,
  parameter int CHANNELS  = 4,
  parameter int CNT_WIDTH = 8
) (
  input logic                  clock,
  input logic                  reset_n,
  range_tracker_multi_if.slave bus
);
  localparam int CH_W = $clog2(CHANNELS);

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DONE, S_ERROR} state_t;

  state_t              state_q [CHANNELS];
  state_t              state_d [CHANNELS];
  logic [CHANNELS-1:0] sel;
  logic [CHANNELS-1:0] do_start;
  logic [CHANNELS-1:0] do_update;
  logic [CHANNELS-1:0] do_latch;
  logic [WIDTH-1:0]    live_min [CHANNELS];
  logic [WIDTH-1:0]    live_max [CHANNELS];
  logic [WIDTH-1:0]    upd_min  [CHANNELS];
  logic [WIDTH-1:0]    upd_max  [CHANNELS];
  logic [WIDTH-1:0]    lat_min  [CHANNELS];
  logic [WIDTH-1:0]    lat_max  [CHANNELS];
`ifdef RANGE_TRACK_COUNT_EN
  logic [CNT_WIDTH-1:0] live_cnt [CHANNELS];
  logic [CNT_WIDTH-1:0] upd_cnt  [CHANNELS];
  logic [CNT_WIDTH-1:0] lat_cnt  [CHANNELS];
`endif

  // Decode chan; an out-of-range index matches no channel, so commands drop.
  always_comb begin
    sel = '0;
    for (int i = 0; i < CHANNELS; i++) sel[i] = (bus.chan == CH_W'(i));
  end

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < CHANNELS; i++) state_q[i] <= S_IDLE;
    end else begin
      for (int i = 0; i < CHANNELS; i++) state_q[i] <= state_d[i];
    end
  end

  // Next-state logic: clear_err first, then go&finish, then normal transitions
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      state_d[i] = state_q[i];
      if (sel[i]) begin
        if (state_q[i] == S_ERROR) begin
          if (bus.clear_err) state_d[i] = S_IDLE;
        end else if (bus.go && bus.finish) begin
          state_d[i] = S_ERROR;
        end else begin
          case (state_q[i])
            S_IDLE, S_DONE: begin
              if (bus.go)          state_d[i] = S_ACTIVE;
              else if (bus.finish) state_d[i] = S_ERROR;
            end
            S_ACTIVE: begin
              if (bus.go)          state_d[i] = S_ERROR;
              else if (bus.finish) state_d[i] = S_DONE;
            end
            default: state_d[i] = state_q[i];
          endcase
        end
      end
    end
  end

  // Outputs: status flags from state, plus datapath strobes for the edge
  always_comb begin
    bus.busy  = '0;
    bus.done  = '0;
    bus.error = '0;
    do_start  = '0;
    do_update = '0;
    do_latch  = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      bus.busy[i]  = (state_q[i] == S_ACTIVE);
      bus.done[i]  = (state_q[i] == S_DONE);
      bus.error[i] = (state_q[i] == S_ERROR);
      do_start[i]  = sel[i] && bus.go && !bus.finish &&
                     (state_q[i] == S_IDLE || state_q[i] == S_DONE);
      do_update[i] = sel[i] && bus.sample && !bus.go && (state_q[i] == S_ACTIVE);
      do_latch[i]  = sel[i] && bus.finish && !bus.go && (state_q[i] == S_ACTIVE);
    end
  end

  // Live values including this cycle's sample, so finish can latch them directly
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      upd_min[i] = live_min[i];
      upd_max[i] = live_max[i];
      if (do_update[i] && bus.data_in < live_min[i]) upd_min[i] = bus.data_in;
      if (do_update[i] && bus.data_in > live_max[i]) upd_max[i] = bus.data_in;
`ifdef RANGE_TRACK_COUNT_EN
      upd_cnt[i] = live_cnt[i];
      if (do_update[i] && live_cnt[i] != {CNT_WIDTH{1'b1}}) upd_cnt[i] = live_cnt[i] + 1'b1;
`endif
    end
  end

  // Live and latched result registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        live_min[i] <= '0;
        live_max[i] <= '0;
        lat_min[i]  <= '0;
        lat_max[i]  <= '0;
`ifdef RANGE_TRACK_COUNT_EN
        live_cnt[i] <= '0;
        lat_cnt[i]  <= '0;
`endif
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (do_start[i]) begin
          live_min[i] <= bus.data_in;
          live_max[i] <= bus.data_in;
`ifdef RANGE_TRACK_COUNT_EN
          live_cnt[i] <= CNT_WIDTH'(1);
`endif
        end else begin
          live_min[i] <= upd_min[i];
          live_max[i] <= upd_max[i];
`ifdef RANGE_TRACK_COUNT_EN
          live_cnt[i] <= upd_cnt[i];
`endif
        end
        if (do_latch[i]) begin
          lat_min[i] <= upd_min[i];
          lat_max[i] <= upd_max[i];
`ifdef RANGE_TRACK_COUNT_EN
          lat_cnt[i] <= upd_cnt[i];
`endif
        end
      end
    end
  end

  // Readout mux; an out-of-range rd_chan reads all zeros
  always_comb begin
    bus.min_out   = '0;
    bus.max_out   = '0;
    bus.range_out = '0;
    bus.count_out = {CNT_WIDTH{1'b0}};
    for (int i = 0; i < CHANNELS; i++) begin
      if (bus.rd_chan == CH_W'(i)) begin
        bus.min_out   = lat_min[i];
        bus.max_out   = lat_max[i];
        bus.range_out = lat_max[i] - lat_min[i];
`ifdef RANGE_TRACK_COUNT_EN
        bus.count_out = lat_cnt[i];
`endif
      end
    end
  end
endmodule

// File: tb/tb_range_tracker_multi.sv
// Randomized + directed bench for range_tracker_multi against a queue-based
// reference model of each channel's measurement.
module tb_range_tracker_multi;
  localparam int WIDTH     = 10;
  localparam int CHANNELS  = 4;
  localparam int CNT_WIDTH = 8;
  localparam int CH_W      = 2;
  localparam int CNT_MAX   = (1 << CNT_WIDTH) - 1;

  localparam int M_IDLE = 0, M_ACT = 1, M_DONE = 2, M_ERR = 3;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #10 clock = ~clock;

  range_tracker_multi_if #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .CNT_WIDTH(CNT_WIDTH)) bus ();

  range_tracker_multi #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .CNT_WIDTH(CNT_WIDTH)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: each channel keeps the list of samples of its running
  // measurement; results are summarised from that list when it finishes.
  int m_state [CHANNELS];
  int m_min   [CHANNELS];
  int m_max   [CHANNELS];
  int m_cnt   [CHANNELS];
  int m_q     [CHANNELS][$];

  function automatic void model_reset();
    for (int c = 0; c < CHANNELS; c++) begin
      m_state[c] = M_IDLE;
      m_min[c] = 0;
      m_max[c] = 0;
      m_cnt[c] = 0;
      m_q[c].delete();
    end
  endfunction

  function automatic void model_step(bit g, bit f, bit s, bit clr, int ch, int d);
    int mn, mx;
    if (ch < 0 || ch >= CHANNELS) return;
    if (m_state[ch] == M_ERR) begin
      if (clr) m_state[ch] = M_IDLE;
      return;
    end
    if (g && f) begin
      m_state[ch] = M_ERR;
      return;
    end
    if (m_state[ch] == M_IDLE || m_state[ch] == M_DONE) begin
      if (g) begin
        m_state[ch] = M_ACT;
        m_q[ch].delete();
        m_q[ch].push_back(d);
      end else if (f) begin
        m_state[ch] = M_ERR;
      end
    end else if (m_state[ch] == M_ACT) begin
      if (g) begin
        m_state[ch] = M_ERR;
      end else begin
        if (s) m_q[ch].push_back(d);
        if (f) begin
          m_state[ch] = M_DONE;
          mn = m_q[ch][0];
          mx = m_q[ch][0];
          foreach (m_q[ch][k]) begin
            if (m_q[ch][k] < mn) mn = m_q[ch][k];
            if (m_q[ch][k] > mx) mx = m_q[ch][k];
          end
          m_min[ch] = mn;
          m_max[ch] = mx;
          m_cnt[ch] = (m_q[ch].size() > CNT_MAX) ? CNT_MAX : m_q[ch].size();
        end
      end
    end
  endfunction

  function automatic int exp_count(int n);
`ifdef RANGE_TRACK_COUNT_EN
    return n;
`else
    return 0;
`endif
  endfunction

  task automatic check_all(input string tag);
    logic [CHANNELS-1:0] eb, ed, ee;
    for (int c = 0; c < CHANNELS; c++) begin
      bus.rd_chan = CH_W'(c);
      #1;
      check_val($sformatf("%s ch%0d min", tag, c), 32'(bus.min_out), m_min[c]);
      check_val($sformatf("%s ch%0d max", tag, c), 32'(bus.max_out), m_max[c]);
      check_val($sformatf("%s ch%0d range", tag, c), 32'(bus.range_out), m_max[c] - m_min[c]);
      check_val($sformatf("%s ch%0d count", tag, c), 32'(bus.count_out), exp_count(m_cnt[c]));
      eb[c] = (m_state[c] == M_ACT);
      ed[c] = (m_state[c] == M_DONE);
      ee[c] = (m_state[c] == M_ERR);
    end
    check_val({tag, " busy"},  32'(bus.busy),  32'(eb));
    check_val({tag, " done"},  32'(bus.done),  32'(ed));
    check_val({tag, " error"}, 32'(bus.error), 32'(ee));
  endtask

  task automatic idle_inputs();
    bus.go = 1'b0; bus.finish = 1'b0; bus.sample = 1'b0; bus.clear_err = 1'b0;
    bus.chan = '0; bus.data_in = '0;
  endtask

  // One clock: drive a command, apply it to the model at the edge, then check.
  task automatic cyc(input string tag, input bit g, input bit f, input bit s,
                     input bit clr, input int ch, input int d);
    bus.go = g; bus.finish = f; bus.sample = s; bus.clear_err = clr;
    bus.chan = CH_W'(ch); bus.data_in = WIDTH'(d);
    @(posedge clock);
    model_step(g, f, s, clr, ch, d);
    @(negedge clock);
    idle_inputs();
    check_all(tag);
  endtask

  task automatic read_ch(input int ch);
    bus.rd_chan = CH_W'(ch);
    #1;
  endtask

  initial begin
    idle_inputs();
    bus.rd_chan = '0;
    model_reset();
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    check_all("reset");

    // Asynchronous reset in the middle of a measurement
    cyc("rst_go", 1, 0, 0, 0, 1, 5);
    cyc("rst_s",  0, 0, 1, 0, 1, 9);
    #2 reset_n = 1'b0;
    #1;
    check_val("async_rst busy", 32'(bus.busy), 0);
    model_reset();
    check_all("async_rst");
    @(negedge clock);
    reset_n = 1'b1;

    // Basic measurement on ch0
    cyc("b_go", 1, 0, 0, 0, 0, 50);
    cyc("b_s1", 0, 0, 1, 0, 0, 20);
    cyc("b_s2", 0, 0, 1, 0, 0, 80);
    cyc("b_s3", 0, 0, 1, 0, 0, 60);
    cyc("b_fin", 0, 1, 1, 0, 0, 10);
    read_ch(0);
    check_val("basic min", 32'(bus.min_out), 10);
    check_val("basic max", 32'(bus.max_out), 80);
    check_val("basic range", 32'(bus.range_out), 70);
    check_val("basic count", 32'(bus.count_out), exp_count(5));
    check_val("basic done0", 32'(bus.done[0]), 1);

    // Restart from DONE keeps old results until the next finish
    cyc("r_go", 1, 0, 0, 0, 0, 400);
    read_ch(0);
    check_val("restart old range", 32'(bus.range_out), 70);
    check_val("restart busy0", 32'(bus.busy[0]), 1);
    cyc("r_fin", 0, 1, 0, 0, 0, 0);
    read_ch(0);
    check_val("restart min", 32'(bus.min_out), 400);
    check_val("restart max", 32'(bus.max_out), 400);
    check_val("restart range", 32'(bus.range_out), 0);
    check_val("restart count", 32'(bus.count_out), exp_count(1));

    // Interleaved channels
    cyc("i_go2", 1, 0, 0, 0, 2, 100);
    cyc("i_go3", 1, 0, 0, 0, 3, 7);
    cyc("i_s2",  0, 0, 1, 0, 2, 300);
    cyc("i_s3",  0, 0, 1, 0, 3, 3);
    cyc("i_f2",  0, 1, 0, 0, 2, 0);
    cyc("i_f3",  0, 1, 0, 0, 3, 0);
    read_ch(2);
    check_val("inter ch2 min", 32'(bus.min_out), 100);
    check_val("inter ch2 range", 32'(bus.range_out), 200);
    read_ch(3);
    check_val("inter ch3 min", 32'(bus.min_out), 3);
    check_val("inter ch3 range", 32'(bus.range_out), 4);
    read_ch(1);
    check_val("inter ch1 untouched", 32'(bus.max_out), 0);

    // Error cases
    cyc("e_fin_idle", 0, 1, 0, 0, 1, 0);
    check_val("err1 set", 32'(bus.error[1]), 1);
    cyc("e_go0", 1, 0, 0, 0, 0, 500);
    cyc("e_rego0", 1, 0, 0, 0, 0, 600);
    check_val("err0 set", 32'(bus.error[0]), 1);
    cyc("e_s0_ignored", 0, 0, 1, 0, 0, 1);
    read_ch(0);
    check_val("err0 frozen max", 32'(bus.max_out), 400);
    cyc("e_gofin3", 1, 1, 0, 0, 3, 0);
    check_val("err3 set", 32'(bus.error[3]), 1);
    cyc("e_clr1", 0, 0, 0, 1, 1, 0);
    check_val("err1 cleared", 32'(bus.error[1]), 0);
    cyc("e_clr0", 0, 0, 0, 1, 0, 0);
    cyc("e_clr3", 0, 0, 0, 1, 3, 0);

    // Saturation and extremes on ch1
    cyc("sat_go", 1, 0, 0, 0, 1, 0);
    for (int k = 0; k < 300; k++) cyc("sat_s", 0, 0, 1, 0, 1, (k % 2 == 0) ? 1023 : 0);
    cyc("sat_fin", 0, 1, 0, 0, 1, 0);
    read_ch(1);
    check_val("sat count", 32'(bus.count_out), exp_count(255));
    check_val("sat min", 32'(bus.min_out), 0);
    check_val("sat max", 32'(bus.max_out), 1023);
    check_val("sat range", 32'(bus.range_out), 1023);

    // Random command mix
    for (int n = 0; n < 400; n++) begin
      int r;
      bit g, f, s, clr;
      r   = $urandom_range(0, 99);
      g   = (r < 12);
      f   = ($urandom_range(0, 99) < 14);
      s   = ($urandom_range(0, 99) < 65);
      clr = ($urandom_range(0, 99) < 15);
      cyc("rand", g, f, s, clr, $urandom_range(0, CHANNELS - 1), $urandom_range(0, 1023));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
